// File: rtl/tx_arbiter.sv
// tx_arbiter: two-requester, frame-locked, round-robin byte arbiter that
// feeds a single transmitter, with a per-byte watchdog that abandons a
// stalled frame and raises a sticky error.
//
// Handshake: a requester holds reqN high with dinN/lastN valid until it
// sees ackN. ackN is a one-cycle pulse that marks the byte as consumed;
// it coincides with tx_start, which hands the byte to the transmitter.
// The transmitter returns a one-cycle tx_done for each tx_start.
module tx_arbiter #(
   parameter int BITS_PER_DATA  = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req0,
   input  logic                     req1,
   input  logic [BITS_PER_DATA-1:0] din0,
   input  logic [BITS_PER_DATA-1:0] din1,
   input  logic                     last0,
   input  logic                     last1,
   output logic                     ack0,
   output logic                     ack1,
   output logic                     tx_start,
   output logic [BITS_PER_DATA-1:0] tx_data,
   input  logic                     tx_done,
   input  logic                     err_clr,
   output logic                     busy,
   output logic                     owner,
   output logic                     timeout_err,
   output logic [1:0]               dbg_state
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_NEXT  = 2'd3
   } state_t;

   state_t                   state_q;
   logic                     tx_start_q;
   logic                     ack0_q;
   logic                     ack1_q;
   logic [BITS_PER_DATA-1:0] tx_data_q;
   logic                     owner_q;
   logic                     err_q;
   logic                     last_flag_q;
   logic                     last_served_q;
   logic [CW-1:0]            cnt_q;

   logic                     win_idle;
   logic                     pick;
   logic                     grant;
   logic [BITS_PER_DATA-1:0] pick_din;
   logic                     pick_last;
   logic                     expired;

   // Grant selection: round-robin on ties in IDLE, owner-only in NEXT.
   always_comb begin
      win_idle  = 1'b0;
      pick      = 1'b0;
      grant     = 1'b0;
      pick_din  = din0;
      pick_last = last0;
      if (req0 && req1) begin
         win_idle = ~last_served_q;
      end else begin
         win_idle = req1;
      end
      if (state_q == S_NEXT) begin
         pick  = owner_q;
         grant = owner_q ? req1 : req0;
      end else if (state_q == S_IDLE) begin
         pick  = win_idle;
         grant = req0 | req1;
      end
      if (pick) begin
         pick_din  = din1;
         pick_last = last1;
      end
      expired = (cnt_q == CNT_LAST);
   end

   // Arbiter FSM with registered pulses, data latch, watchdog and error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         tx_start_q    <= 1'b0;
         ack0_q        <= 1'b0;
         ack1_q        <= 1'b0;
         tx_data_q     <= '0;
         owner_q       <= 1'b0;
         err_q         <= 1'b0;
         last_flag_q   <= 1'b0;
         last_served_q <= 1'b1;
         cnt_q         <= '0;
      end else begin
         tx_start_q <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         // A timeout set below overrides this clear in the same cycle.
         if (err_clr) begin
            err_q <= 1'b0;
         end
         case (state_q)
            S_IDLE, S_NEXT: begin
               if (grant) begin
                  owner_q     <= pick;
                  tx_data_q   <= pick_din;
                  last_flag_q <= pick_last;
                  tx_start_q  <= 1'b1;
                  ack0_q      <= ~pick;
                  ack1_q      <= pick;
                  state_q     <= S_START;
               end else if (state_q == S_NEXT) begin
                  if (expired) begin
                     state_q       <= S_IDLE;
                     err_q         <= 1'b1;
                     last_served_q <= owner_q;
                     cnt_q         <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_START: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (tx_done) begin
                  cnt_q <= '0;
                  if (last_flag_q) begin
                     state_q       <= S_IDLE;
                     last_served_q <= owner_q;
                  end else begin
                     state_q <= S_NEXT;
                  end
               end else if (expired) begin
                  state_q       <= S_IDLE;
                  err_q         <= 1'b1;
                  last_served_q <= owner_q;
                  cnt_q         <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ack0        = ack0_q;
   assign ack1        = ack1_q;
   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign owner       = owner_q;
   assign timeout_err = err_q;
   assign busy        = (state_q != S_IDLE);
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: cycle-table vectors plus hand-written timeout and reset
// sequences; every tx_start is checked against an expected-byte queue.
module tb_tx_arbiter;

   localparam int W  = 8;
   localparam int TC = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic [W-1:0] din0 = '0, din1 = '0;
   logic         last0 = 1'b0, last1 = 1'b0;
   logic         tx_done = 1'b0, err_clr = 1'b0;
   logic         ack0, ack1, tx_start, busy, owner, timeout_err;
   logic [W-1:0] tx_data;
   logic [1:0]   dbg_state;

   int total = 0;
   int bad   = 0;

   logic [W:0] exp_q[$];

   tx_arbiter #(.BITS_PER_DATA(W), .TIMEOUT_CYCLES(TC)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .din0(din0), .din1(din1),
      .last0(last0), .last1(last1), .ack0(ack0), .ack1(ack1),
      .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
      .err_clr(err_clr), .busy(busy), .owner(owner),
      .timeout_err(timeout_err), .dbg_state(dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   typedef struct {
      logic         r0, r1;
      logic [W-1:0] d0, d1;
      logic         l0, l1, td;
      logic         ts, a0, a1;
      logic [W-1:0] dat;
      logic         bs, ow;
   } vec_t;

   function automatic vec_t mk(input logic r0, r1, input logic [W-1:0] d0, d1,
                               input logic l0, l1, td, ts, a0, a1,
                               input logic [W-1:0] dat, input logic bs, ow);
      vec_t v;
      v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1;
      v.l0 = l0; v.l1 = l1; v.td = td;
      v.ts = ts; v.a0 = a0; v.a1 = a1; v.dat = dat; v.bs = bs; v.ow = ow;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r0, r1, input logic [W-1:0] d0, d1, input logic l0, l1);
      req0 = r0; req1 = r1; din0 = d0; din1 = d1; last0 = l0; last1 = l1;
   endtask

   // scoreboard: every tx_start must match the oldest expected {owner, byte}
   always @(posedge clk) begin
      logic [W:0] e;
      #1;
      if (ack0 && ack1) begin
         chk("ack_exclusive", {ack0, ack1}, 2'b00);
      end
      if (tx_start) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_start", {owner, tx_data}, 0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_start", {owner, tx_data, ack0, ack1}, {e, ~e[W], e[W]});
         end
      end
   end

   vec_t vecs[$];

   initial begin
      int waits;

      // table: one row per clock, inputs applied then outputs after the edge
      vecs.push_back(mk(1,1,8'hA0,8'hB0,1,1,0, 1,1,0,8'hA0,1,0));
      vecs.push_back(mk(1,1,8'hA0,8'hB0,1,1,0, 0,0,0,8'hA0,1,0));
      vecs.push_back(mk(1,1,8'hA0,8'hB0,1,1,1, 0,0,0,8'hA0,0,0));
      vecs.push_back(mk(1,1,8'hA1,8'hB0,1,1,0, 1,0,1,8'hB0,1,1));
      vecs.push_back(mk(1,1,8'hA1,8'hB0,1,1,0, 0,0,0,8'hB0,1,1));
      vecs.push_back(mk(1,1,8'hA1,8'hB0,1,1,1, 0,0,0,8'hB0,0,1));
      vecs.push_back(mk(1,1,8'hA1,8'hB1,1,1,0, 1,1,0,8'hA1,1,0));
      vecs.push_back(mk(0,0,8'hA1,8'hB1,1,1,0, 0,0,0,8'hA1,1,0));
      vecs.push_back(mk(0,0,8'h00,8'h00,0,0,1, 0,0,0,8'hA1,0,0));
      vecs.push_back(mk(0,0,8'h00,8'h00,0,0,1, 0,0,0,8'hA1,0,0));
      vecs.push_back(mk(0,1,8'h00,8'h33,0,1,0, 1,0,1,8'h33,1,1));
      vecs.push_back(mk(0,0,8'h00,8'h00,0,0,0, 0,0,0,8'h33,1,1));
      vecs.push_back(mk(0,0,8'h00,8'h00,0,0,1, 0,0,0,8'h33,0,1));
      vecs.push_back(mk(1,1,8'h01,8'hEE,0,1,0, 1,1,0,8'h01,1,0));
      vecs.push_back(mk(1,1,8'h01,8'hEE,0,1,0, 0,0,0,8'h01,1,0));
      vecs.push_back(mk(1,1,8'h01,8'hEE,0,1,1, 0,0,0,8'h01,1,0));
      vecs.push_back(mk(0,1,8'h02,8'hEE,0,1,0, 0,0,0,8'h01,1,0));
      vecs.push_back(mk(1,1,8'h02,8'hEE,0,1,0, 1,1,0,8'h02,1,0));
      vecs.push_back(mk(1,1,8'h02,8'hEE,0,1,0, 0,0,0,8'h02,1,0));
      vecs.push_back(mk(1,1,8'h03,8'hEE,1,1,1, 0,0,0,8'h02,1,0));
      vecs.push_back(mk(1,1,8'h03,8'hEE,1,1,0, 1,1,0,8'h03,1,0));
      vecs.push_back(mk(0,1,8'h03,8'hEE,0,1,0, 0,0,0,8'h03,1,0));
      vecs.push_back(mk(0,1,8'h00,8'hEE,0,1,1, 0,0,0,8'h03,0,0));
      vecs.push_back(mk(0,1,8'h00,8'hEE,0,1,0, 1,0,1,8'hEE,1,1));
      vecs.push_back(mk(0,0,8'h00,8'h00,0,0,0, 0,0,0,8'hEE,1,1));
      vecs.push_back(mk(0,0,8'h00,8'h00,0,0,1, 0,0,0,8'hEE,0,1));
      vecs.push_back(mk(1,0,8'h55,8'h00,1,0,0, 1,1,0,8'h55,1,0));
      vecs.push_back(mk(0,0,8'h00,8'h00,0,0,0, 0,0,0,8'h55,1,0));
      vecs.push_back(mk(0,0,8'h00,8'h00,0,0,1, 0,0,0,8'h55,0,0));

      // reset block
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {tx_start, ack0, ack1, tx_data, busy, owner, timeout_err, dbg_state},
          0);
      reset = 1'b0;

      // table-driven vectors
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1, vecs[i].l0, vecs[i].l1);
         tx_done = vecs[i].td;
         if (vecs[i].ts) exp_q.push_back({vecs[i].ow, vecs[i].dat});
         step();
         chk($sformatf("vec%0d", i),
             {tx_start, ack0, ack1, tx_data, busy, owner, timeout_err},
             {vecs[i].ts, vecs[i].a0, vecs[i].a1, vecs[i].dat, vecs[i].bs, vecs[i].ow, 1'b0});
      end
      tx_done = 1'b0;

      // timeout in WAIT: 16 WAIT cycles after the tx_start cycle, then IDLE
      drive(1, 0, 8'h77, 8'h00, 1, 0);
      exp_q.push_back({1'b0, 8'h77});
      step();
      drive(0, 0, 8'h00, 8'h00, 0, 0);
      waits = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (!busy) break;
         waits++;
      end
      chk("timeout_wait_cycles", waits, TC);
      chk("timeout_flag", {busy, timeout_err, tx_data}, {1'b0, 1'b1, 8'h77});
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("err_clr", timeout_err, 0);

      // tx_done on the timeout cycle: done wins, no error
      drive(1, 0, 8'h88, 8'h00, 1, 0);
      exp_q.push_back({1'b0, 8'h88});
      step();
      drive(0, 0, 8'h00, 8'h00, 0, 0);
      repeat (TC) step();
      chk("collision_still_busy", {busy, timeout_err}, 2'b10);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk("collision_done_wins", {busy, timeout_err}, 2'b00);

      // NEXT: owner request on the timeout cycle wins; other requester ignored
      drive(1, 0, 8'h91, 8'h00, 0, 0);
      exp_q.push_back({1'b0, 8'h91});
      step();
      drive(0, 0, 8'h00, 8'h00, 0, 0);
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      drive(0, 1, 8'h00, 8'hCC, 0, 1);
      repeat (TC - 1) step();
      chk("next_locked", {busy, tx_start, timeout_err}, 3'b100);
      drive(1, 1, 8'h92, 8'hCC, 1, 1);
      exp_q.push_back({1'b0, 8'h92});
      step();
      chk("next_req_wins", {tx_start, owner, tx_data, timeout_err}, {1'b1, 1'b0, 8'h92, 1'b0});
      drive(0, 0, 8'h00, 8'h00, 0, 0);
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk("next_frame_end", busy, 0);

      // NEXT timeout with err_clr on the same edge: set wins
      drive(1, 0, 8'hA5, 8'h00, 0, 0);
      exp_q.push_back({1'b0, 8'hA5});
      step();
      drive(0, 0, 8'h00, 8'h00, 0, 0);
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      repeat (TC - 1) step();
      chk("next_before_timeout", {busy, timeout_err}, 2'b10);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("set_beats_clr", {busy, tx_start, timeout_err}, 3'b001);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("clr_after_set", timeout_err, 0);

      // reset asserted while in WAIT clears everything without a clock edge
      drive(1, 0, 8'h5A, 8'h00, 1, 0);
      exp_q.push_back({1'b0, 8'h5A});
      step();
      drive(0, 0, 8'h00, 8'h00, 0, 0);
      step();
      chk("pre_reset_wait", {busy, dbg_state}, {1'b1, 2'd2});
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset", {tx_start, ack0, ack1, tx_data, busy, owner, timeout_err, dbg_state},
          0);
      drive(1, 1, 8'hC3, 8'h3C, 1, 1);
      step();
      step();
      chk("held_in_reset", {tx_start, busy}, 2'b00);
      reset = 1'b0;
      exp_q.push_back({1'b0, 8'hC3});
      step();
      chk("post_reset_tie", {tx_start, ack0, owner, tx_data}, {1'b1, 1'b1, 1'b0, 8'hC3});
      drive(0, 0, 8'h00, 8'h00, 0, 0);
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk("post_reset_idle", busy, 0);

      step();
      chk("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 The block SHALL have parameter BITS_PER_DATA, default 8, byte width of requester and transmitter data.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, max clk cycles allowed in WAIT or NEXT before abort; counter width SHALL be clog2(TIMEOUT_CYCLES).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0, req1  input  1 each  requester has a byte on din0/din1.
REQ-006 din0, din1  input  BITS_PER_DATA each  requester byte.
REQ-007 last0, last1  input  1 each  presented byte is final byte of its frame.
REQ-008 ack0, ack1  output  1 each  registered one-cycle pulse: byte consumed.
REQ-009 tx_start  output  1  registered one-cycle pulse to transmitter, active-high.
REQ-010 tx_data  output  BITS_PER_DATA  byte to transmitter.
REQ-011 tx_done  input  1  one-cycle pulse from transmitter, byte sent.
REQ-012 err_clr  input  1  clears timeout_err.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 owner  output  1  index of granted requester.
REQ-015 timeout_err  output  1  sticky abort flag.

Function
REQ-016 States SHALL be IDLE, START, WAIT, NEXT.
REQ-017 IDLE: if any req, winner SHALL be latched at the clock edge (owner, tx_data <= din, last_flag <= last); next state START.
REQ-018 Both req in IDLE: winner SHALL be the requester not equal to last_served (round-robin per frame); single req wins unconditionally.
REQ-019 START: lasts exactly one cycle; tx_start=1 and ack[owner]=1 in that cycle; next state WAIT; timeout counter cleared.
REQ-020 Latency: req sampled in IDLE at cycle N -> tx_start and ack at cycle N+1.
REQ-021 tx_data SHALL stay stable from START until the next latch; never changes during WAIT.
REQ-022 WAIT: on tx_done, if last_flag=1 -> IDLE with last_served <= owner; else -> NEXT, counter cleared.
REQ-023 NEXT: only req[owner] is considered (frame lock, other requester ignored); when high, latch din/last of owner, -> START.
REQ-024 WAIT/NEXT: counter increments each cycle; at TIMEOUT_CYCLES-1 without exit event -> IDLE, timeout_err <= 1, last_served <= owner, frame abandoned.
REQ-025 tx_done and timeout in same cycle: tx_done SHALL win, no error.
REQ-026 req[owner] and timeout in same cycle in NEXT: req SHALL win.
REQ-027 tx_done outside WAIT SHALL be ignored.
REQ-028 err_clr clears timeout_err next edge; timeout set and err_clr same cycle -> set wins.
REQ-029 ack0 and ack1 SHALL never be high simultaneously; at most one tx_start per tx_done.

Reset
REQ-030 reset high SHALL force immediately: state IDLE, tx_start=0, ack0=ack1=0, tx_data=0, busy=0, owner=0, timeout_err=0, counter=0, last_flag=0, last_served=1 (requester 0 wins first tie).
REQ-031 reset mid-frame SHALL abandon the frame with no further tx_start or ack; first edge after release evaluates IDLE.

Verification
REQ-032 Single byte: req0=1, din0=0x55, last0=1 -> next cycle tx_start=1, ack0=1, tx_data=0x55; tx_done -> IDLE, busy=0.
REQ-033 Tie: req0=req1=1 both single-byte frames after reset -> requester 0 served, then requester 1, then 0 (alternating).
REQ-034 Frame lock: req0 3-byte frame 0x01,0x02,0x03(last) with req1 held high -> three tx_start pulses with owner=0 before any ack1.
REQ-035 Timeout: TIMEOUT_CYCLES=16, tx_done never asserted -> 16 cycles after tx_start enter IDLE, timeout_err=1; err_clr -> 0.
REQ-036 Edge collisions: tx_done on timeout cycle -> no error; reset asserted in WAIT -> all outputs 0 asynchronously, tx_data=0.
